// File: rtl/scaler.sv
// Nearest-neighbour video scaler: windows an input raster into a two-bank line buffer
// and replays it at outXRes x outYRes with its own HS/VS. Optional crop: SCALER_CROP_EN.
module scaler #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned INPUT_RES_WIDTH = 11,
    parameter int unsigned SCALE_FRAC_BITS = 6,
    parameter int unsigned SCALE_INT_BITS  = 2,
    parameter int unsigned RAM_SIZE_WIDTH  = 11
) (
    input  logic                       clka,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       iHsyn,
    input  logic                       iVsyn,
    input  logic [DATA_WIDTH-1:0]      dIn,
    input  logic                       dInEn,
    input  logic [INPUT_RES_WIDTH-1:0] xBgn,
    input  logic [INPUT_RES_WIDTH-1:0] xEnd,
    input  logic [INPUT_RES_WIDTH-1:0] yBgn,
    input  logic [INPUT_RES_WIDTH-1:0] yEnd,
    input  logic [INPUT_RES_WIDTH-1:0] inXRes,
    input  logic [INPUT_RES_WIDTH-1:0] inYRes,
    input  logic [INPUT_RES_WIDTH-1:0] outXRes,
    input  logic [INPUT_RES_WIDTH-1:0] outYRes,
    output logic [DATA_WIDTH-1:0]      dOut,
    output logic                       dOutEn,
    output logic                       HS,
    output logic                       VS
);
    localparam int unsigned RW        = INPUT_RES_WIDTH;
    localparam int unsigned KW        = SCALE_INT_BITS + SCALE_FRAC_BITS;
    localparam int unsigned QW        = INPUT_RES_WIDTH + SCALE_FRAC_BITS;
    localparam int unsigned AYW       = QW + 1;
    localparam int unsigned SRW       = AYW - SCALE_FRAC_BITS;
    localparam int unsigned CW        = $clog2(QW + 1);
    localparam int unsigned AW        = RAM_SIZE_WIDTH;
    localparam int unsigned RAM_DEPTH = 2 ** (AW + 1);
    localparam logic [KW-1:0] K_ONE   = KW'(1 << SCALE_FRAC_BITS);

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_HSYNC} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         in_x_q, in_x_d, in_y_q, in_y_d;
    logic                  vsyn_q, vsyn_d, frame_vld_q, frame_vld_d;
    logic                  wr_bank_q, wr_bank_d, pend_q, pend_d, pend_bank_q, pend_bank_d;
    logic [RW-1:0]         pend_row_q, pend_row_d, col_q, col_d, out_row_q, out_row_d;
    logic [QW-1:0]         acc_x_q, acc_x_d;
    logic [AYW-1:0]        acc_y_q, acc_y_d;
    logic [KW-1:0]         k_x_q, k_x_d, k_y_q, k_y_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [QW-1:0]         qx_q, qx_d, qy_q, qy_d;
    logic [RW-1:0]         rx_q, rx_d, ry_q, ry_d;
    logic                  rd_vld_q, rd_vld_d, dout_en_q, dout_en_d, hs_q, hs_d, vs_q, vs_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, ram_rd_q;
    logic                  release_c;

    logic [RW-1:0] x_bgn, x_end, y_bgn, y_end;
`ifdef SCALER_CROP_EN
    assign x_bgn = xBgn;
    assign x_end = xEnd;
    assign y_bgn = yBgn;
    assign y_end = yEnd;
`else
    assign x_bgn = '0;
    assign x_end = inXRes - RW'(1);
    assign y_bgn = '0;
    assign y_end = inYRes - RW'(1);
    logic crop_unused;
    assign crop_unused = ^{xBgn, xEnd, yBgn, yEnd};
`endif

    logic [RW-1:0]  win_w, win_h;
    logic           x_in_win, y_in_win, wr_en, rd_en, line_done, vs_rise;
    logic [AW:0]    wr_addr, rd_addr;
    logic [SRW-1:0] src_row;
    logic           row_hit, row_past, out_row_ok;

    assign win_w      = x_end - x_bgn + RW'(1);
    assign win_h      = y_end - y_bgn + RW'(1);
    assign x_in_win   = (in_x_q >= x_bgn) && (in_x_q <= x_end) && (in_x_q < inXRes);
    assign y_in_win   = (in_y_q >= y_bgn) && (in_y_q <= y_end) && (in_y_q < inYRes);
    assign wr_en      = en && dInEn && !iVsyn && x_in_win && y_in_win;
    assign wr_addr    = {wr_bank_q, AW'(in_x_q - x_bgn)};
    assign line_done  = en && iHsyn && !iVsyn && y_in_win && frame_vld_q;
    assign vs_rise    = en && iVsyn && !vsyn_q;
    assign rd_en      = en && (state_q == S_ROW);
    assign rd_addr    = {pend_bank_q, AW'(acc_x_q >> SCALE_FRAC_BITS)};
    assign src_row    = SRW'(acc_y_q >> SCALE_FRAC_BITS);
    assign row_hit    = (src_row == SRW'(pend_row_q));
    assign row_past   = (src_row > SRW'(pend_row_q));
    assign out_row_ok = (out_row_q < outYRes);

    // One restoring-division step: {remainder, dividend/quotient shift register}
    function automatic logic [RW+QW-1:0] div_step(input logic [RW-1:0] rem,
                                                  input logic [QW-1:0] num,
                                                  input logic [RW-1:0] den);
        logic [RW:0] sh;
        sh = {rem, num[QW-1]};
        if (sh >= {1'b0, den}) return {RW'(sh - {1'b0, den}), num[QW-2:0], 1'b1};
        return {RW'(sh), num[QW-2:0], 1'b0};
    endfunction

    function automatic logic [KW-1:0] k_sat(input logic [QW-1:0] q);
        if ((q >> KW) != '0) return '1;
        return KW'(q);
    endfunction

    // Two-bank line buffer
    logic [DATA_WIDTH-1:0] line_mem [RAM_DEPTH];
    always_ff @(posedge clka) begin
        if (wr_en) line_mem[wr_addr] <= dIn;
        if (rd_en) ram_rd_q <= line_mem[rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        in_x_d      = in_x_q;
        in_y_d      = in_y_q;
        vsyn_d      = vsyn_q;
        frame_vld_d = frame_vld_q;
        wr_bank_d   = wr_bank_q;
        pend_d      = pend_q;
        pend_bank_d = pend_bank_q;
        pend_row_d  = pend_row_q;
        col_d       = col_q;
        out_row_d   = out_row_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        k_x_d       = k_x_q;
        k_y_d       = k_y_q;
        div_cnt_d   = div_cnt_q;
        qx_d        = qx_q;
        qy_d        = qy_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        rd_vld_d    = rd_vld_q;
        release_c   = 1'b0;
        dout_d      = (en && rd_vld_q) ? ram_rd_q : '0;
        dout_en_d   = en && rd_vld_q;
        hs_d        = en && dout_en_q && !rd_vld_q;
        vs_d        = vs_rise;

        if (en) begin
            vsyn_d   = iVsyn;
            rd_vld_d = (state_q == S_ROW);
            if (iVsyn) begin
                in_x_d = '0;
                in_y_d = '0;
            end else if (iHsyn) begin
                in_y_d = in_y_q + RW'(1);
                in_x_d = '0;
            end else if (dInEn) begin
                in_x_d = in_x_q + RW'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        if (row_hit && out_row_ok) begin
                            state_d = S_ROW;
                            acc_x_d = '0;
                            col_d   = '0;
                        end else if (row_past) begin
                            release_c = 1'b1;
                        end
                    end
                end
                S_ROW: begin
                    acc_x_d = acc_x_q + QW'(k_x_q);
                    col_d   = col_q + RW'(1);
                    if (col_q == outXRes - RW'(1)) begin
                        state_d   = S_HSYNC;
                        acc_y_d   = acc_y_q + AYW'(k_y_q);
                        out_row_d = out_row_q + RW'(1);
                    end
                end
                S_HSYNC: begin
                    if (row_hit && out_row_ok) begin
                        state_d = S_ROW;
                        acc_x_d = '0;
                        col_d   = '0;
                    end else begin
                        state_d   = S_IDLE;
                        release_c = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (release_c) pend_d = 1'b0;
            // A line finishing while the other bank is still held is dropped
            if (line_done && (!pend_q || release_c)) begin
                pend_d      = 1'b1;
                pend_bank_d = wr_bank_q;
                pend_row_d  = in_y_q - y_bgn;
                wr_bank_d   = !wr_bank_q;
            end

            if (vs_rise) begin
                state_d     = S_IDLE;
                acc_y_d     = '0;
                out_row_d   = '0;
                pend_d      = 1'b0;
                frame_vld_d = 1'b1;
                div_cnt_d   = CW'(QW);
                qx_d        = QW'(win_w) << SCALE_FRAC_BITS;
                qy_d        = QW'(win_h) << SCALE_FRAC_BITS;
                rx_d        = '0;
                ry_d        = '0;
            end else if (div_cnt_q != '0) begin
                {rx_d, qx_d} = div_step(rx_q, qx_q, outXRes);
                {ry_d, qy_d} = div_step(ry_q, qy_q, outYRes);
                div_cnt_d    = div_cnt_q - CW'(1);
                if (div_cnt_q == CW'(1)) begin
                    k_x_d = k_sat(qx_d);
                    k_y_d = k_sat(qy_d);
                end
            end
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_x_q      <= '0;
            in_y_q      <= '0;
            vsyn_q      <= 1'b1;
            frame_vld_q <= 1'b0;
            wr_bank_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            pend_row_q  <= '0;
            col_q       <= '0;
            out_row_q   <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            k_x_q       <= K_ONE;
            k_y_q       <= K_ONE;
            div_cnt_q   <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            rd_vld_q    <= 1'b0;
            dout_q      <= '0;
            dout_en_q   <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_x_q      <= in_x_d;
            in_y_q      <= in_y_d;
            vsyn_q      <= vsyn_d;
            frame_vld_q <= frame_vld_d;
            wr_bank_q   <= wr_bank_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            pend_row_q  <= pend_row_d;
            col_q       <= col_d;
            out_row_q   <= out_row_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            k_x_q       <= k_x_d;
            k_y_q       <= k_y_d;
            div_cnt_q   <= div_cnt_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            rd_vld_q    <= rd_vld_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    assign dOut   = dout_q;
    assign dOutEn = dout_en_q;
    assign HS     = hs_q;
    assign VS     = vs_q;

endmodule

// File: tb/tb_scaler.sv
// Directed testbench for scaler: upscale, downscale, crop, enable-low and mid-row reset.
module tb_scaler;
    localparam int unsigned DW = 16;
    localparam int unsigned RW = 11;

    typedef struct packed {
        int in_x; int in_y; int xb; int xe; int yb; int ye;
        int out_x; int out_y; int lat_row; int exp_off; int exp_n;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, en, iHsyn, iVsyn, dInEn;
    logic [DW-1:0] dIn;
    logic [RW-1:0] xBgn, xEnd, yBgn, yEnd, inXRes, inYRes, outXRes, outYRes;
    logic [DW-1:0] dOut;
    logic          dOutEn, HS, VS;

    scaler dut (
        .clka(clk), .rst(rst), .en(en), .iHsyn(iHsyn), .iVsyn(iVsyn),
        .dIn(dIn), .dInEn(dInEn),
        .xBgn(xBgn), .xEnd(xEnd), .yBgn(yBgn), .yEnd(yEnd),
        .inXRes(inXRes), .inYRes(inYRes), .outXRes(outXRes), .outYRes(outYRes),
        .dOut(dOut), .dOutEn(dOutEn), .HS(HS), .VS(VS)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pixel log, pulse counts and burst/HS shape errors
    int            n_en = 0, n_hs = 0, n_vs = 0, n_hs_err = 0, run_len = 0, mon_out_x = 0;
    logic          prev_en = 1'b0;
    logic [DW-1:0] pix [1024];
    int            en_cyc [1024];
    always @(negedge clk) begin
        if (prev_en && !dOutEn) begin
            if (!HS || run_len != mon_out_x) n_hs_err++;
        end else if (HS) begin
            n_hs_err++;
        end
        if (dOutEn) begin
            if (n_en < 1024) begin
                pix[n_en]    = dOut;
                en_cyc[n_en] = cyc;
            end
            n_en++;
            run_len = prev_en ? run_len + 1 : 1;
        end
        if (HS) n_hs++;
        if (VS) n_vs++;
        prev_en = dOutEn;
    end

    int exp_up [36] = '{1,1,2,2,3,3, 1,1,2,2,3,3, 4,4,5,5,6,6,
                        4,4,5,5,6,6, 7,7,8,8,9,9, 7,7,8,8,9,9};
    int exp_dn [9]  = '{1,3,5, 13,15,17, 25,27,29};
`ifdef SCALER_CROP_EN
    int exp_cr [4]  = '{6,7, 10,11};
`else
    int exp_cr [16] = '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16};
`endif
    int   exp_all [$];
    vec_t vecs [3];
    int   n_chk = 0, n_pass = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic set_cfg(input vec_t v);
        inXRes  = RW'(v.in_x);
        inYRes  = RW'(v.in_y);
        xBgn    = RW'(v.xb);
        xEnd    = RW'(v.xe);
        yBgn    = RW'(v.yb);
        yEnd    = RW'(v.ye);
        outXRes = RW'(v.out_x);
        outYRes = RW'(v.out_y);
        mon_out_x = v.out_x;
    endtask

    task automatic frame_start();
        iVsyn = 1'b1;
        repeat (25) tick();
        iVsyn = 1'b0;
        repeat (4) tick();
    endtask

    task automatic drive_row(input int in_x, input int y);
        for (int x = 0; x < in_x; x++) begin
            dIn   = DW'(y * in_x + x + 1);
            dInEn = 1'b1;
            tick();
        end
        dInEn = 1'b0;
        iHsyn = 1'b1;
        tick();
        iHsyn = 1'b0;
    endtask

    // Ramp frame; hs_cyc is the cycle of the edge that samples iHsyn on row lat_row
    task automatic drive_frame(input int in_x, input int in_y, input int lat_row,
                               output int hs_cyc);
        hs_cyc = -1000;
        frame_start();
        for (int y = 0; y < in_y; y++) begin
            if (y == lat_row) hs_cyc = cyc + 1 + in_x;
            drive_row(in_x, y);
            repeat (40) tick();
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int b_en, b_hs, b_vs, b_err, hs_cyc, got_n;
        b_en = n_en; b_hs = n_hs; b_vs = n_vs; b_err = n_hs_err;
        set_cfg(v);
        drive_frame(v.in_x, v.in_y, v.lat_row, hs_cyc);
        got_n = n_en - b_en;
        check($sformatf("%s.pixels", tag), got_n, v.exp_n);
        for (int i = 0; i < v.exp_n && i < got_n; i++)
            check($sformatf("%s.pix%0d", tag, i), int'(pix[b_en + i]), exp_all[v.exp_off + i]);
        check($sformatf("%s.hs", tag), n_hs - b_hs, v.out_y);
        check($sformatf("%s.vs", tag), n_vs - b_vs, 1);
        check($sformatf("%s.burst_shape", tag), n_hs_err - b_err, 0);
        check($sformatf("%s.latency", tag), (got_n > 0) ? en_cyc[b_en] - hs_cyc : -1, 3);
    endtask

    initial begin
        int b_en, b_hs, b_vs, hs_cyc;
        rst = 1'b1; en = 1'b1; iHsyn = 1'b0; iVsyn = 1'b0; dIn = '0; dInEn = 1'b0;
        foreach (exp_up[i]) exp_all.push_back(exp_up[i]);
        foreach (exp_dn[i]) exp_all.push_back(exp_dn[i]);
        foreach (exp_cr[i]) exp_all.push_back(exp_cr[i]);
        vecs[0] = '{3, 3, 0, 2, 0, 2, 6, 6, 0, 0, 36};
        vecs[1] = '{6, 6, 0, 5, 0, 5, 3, 3, 0, 36, 9};
`ifdef SCALER_CROP_EN
        vecs[2] = '{4, 4, 1, 2, 1, 2, 2, 2, 1, 45, 4};
`else
        vecs[2] = '{4, 4, 1, 2, 1, 2, 4, 4, 0, 45, 16};
`endif
        set_cfg(vecs[0]);

        #2 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();
        check("reset.dOut", int'(dOut), 0);
        check("reset.dOutEn", int'(dOutEn), 0);
        check("reset.HS", int'(HS), 0);
        check("reset.VS", int'(VS), 0);

        for (int i = 0; i < 3; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Whole frame with the block disabled
        b_en = n_en; b_hs = n_hs; b_vs = n_vs;
        set_cfg(vecs[0]);
        en = 1'b0;
        drive_frame(3, 3, 0, hs_cyc);
        en = 1'b1;
        tick();
        check("en_low.pixels", n_en - b_en, 0);
        check("en_low.hs", n_hs - b_hs, 0);
        check("en_low.vs", n_vs - b_vs, 0);

        // Reset asserted in the middle of an output burst
        set_cfg(vecs[0]);
        frame_start();
        drive_row(3, 0);
        repeat (5) tick();
        check("rst_mid.pre_en", int'(dOutEn), 1);
        rst = 1'b0;
        #1;
        check("rst_mid.dOut", int'(dOut), 0);
        check("rst_mid.dOutEn", int'(dOutEn), 0);
        check("rst_mid.HS", int'(HS), 0);
        check("rst_mid.VS", int'(VS), 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        b_en = n_en; b_hs = n_hs; b_vs = n_vs;
        for (int y = 1; y < 3; y++) begin
            drive_row(3, y);
            repeat (40) tick();
        end
        check("rst_mid.post_pixels", n_en - b_en, 0);
        check("rst_mid.post_hs", n_hs - b_hs, 0);
        check("rst_mid.post_vs", n_vs - b_vs, 0);
        run_vec("after_rst", vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
